mem_stage: RTL and testbench

Memory-access pipeline stage directly downstream of the execute stage. Consumes the registered memory op, size, address, store data and ALU result, performs loads and stores over a single-outstanding req/ready data-memory port, aligns and extends load data, and presents registered writeback data. While a memory access is pending it stalls everything upstream.

---
 rtl/mem_stage_pkg.sv | 41 ++++
 rtl/mem_stage_load_extend.sv | 31 +++
 rtl/mem_stage.sv | 220 ++++++++++++++++++++++
 tb/tb_mem_stage.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared memory-access encodings: op/size codes, stage state, byte-lane masks.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    MemNone  = 2'b00,
    MemLoad  = 2'b01,
    MemStore = 2'b10,
    MemLoadu = 2'b11
  } mem_op_e;

  typedef enum logic [1:0] {
    SizeByte = 2'b00,
    SizeHalf = 2'b01,
    SizeWord = 2'b10,
    SizeRsvd = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StReq  = 2'b01,
    StDone = 2'b10
  } mem_state_e;

  // Byte-enable masks for lane 0; shifted left by the low address bits.
  localparam logic [3:0] LanesByte = 4'b0001;
  localparam logic [3:0] LanesHalf = 4'b0011;
  localparam logic [3:0] LanesWord = 4'b1111;

  // True when the access cannot be issued: misaligned or reserved size.
  function automatic logic access_fault(mem_size_e size, logic [1:0] lane);
    logic flt;
    case (size)
      SizeByte: flt = 1'b0;
      SizeHalf: flt = lane[0];
      SizeWord: flt = (lane != 2'b00);
      default:  flt = 1'b1;
    endcase
    return flt;
  endfunction

endpackage

// File: rtl/mem_stage_load_extend.sv
// Load alignment: picks the addressed byte/half lane and sign- or zero-extends it.
module mem_stage_load_extend
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  mem_size_e   size,
  input  logic        is_unsigned,
  output logic [31:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select then extension; word accesses pass straight through.
  always_comb begin
    case (lane)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SizeByte: value = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      SizeHalf: value = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      default:  value = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: single-outstanding data-memory access, load alignment,
// registered writeback, upstream stall while an access is in flight.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  memOpIn,
  input  logic [1:0]  memSizeIn,
  input  logic [31:0] addrIn,
  input  logic [31:0] dinIn,
  input  logic [31:0] aluIn,
  input  logic [4:0]  rdIn,
  input  logic        regWriteIn,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] wbData,
  output logic [4:0]  wbRd,
  output logic        wbWe,
  output logic        fault
);

  mem_state_e  state_q, state_d;
  mem_op_e     op_q, op_d;
  mem_size_e   size_q, size_d;
  logic [1:0]  lane_q, lane_d;
  logic [4:0]  rd_q, rd_d;
  logic        rwe_q, rwe_d;
  logic [31:0] rdata_q, rdata_d;
  logic        aborted_q, aborted_d;
  logic [15:0] cnt_q, cnt_d;

  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_we_q, wb_we_d;
  logic        fault_q, fault_d;

  mem_op_e     op_in;
  mem_size_e   size_in;
  logic        bad_in;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [16:0] cnt_inc;
  logic [31:0] load_val;

  assign op_in   = mem_op_e'(memOpIn);
  assign size_in = mem_size_e'(memSizeIn);
  assign bad_in  = access_fault(size_in, addrIn[1:0]);
  assign cnt_inc = {1'b0, cnt_q} + 17'd1;

  // Byte enables and lane-replicated store data for the incoming access.
  always_comb begin
    case (size_in)
      SizeByte: begin
        st_be    = LanesByte << addrIn[1:0];
        st_wdata = {4{dinIn[7:0]}};
      end
      SizeHalf: begin
        st_be    = LanesHalf << addrIn[1:0];
        st_wdata = {2{dinIn[15:0]}};
      end
      default: begin
        st_be    = LanesWord;
        st_wdata = dinIn;
      end
    endcase
  end

  mem_stage_load_extend u_load_extend (
    .rdata       (rdata_q),
    .lane        (lane_q),
    .size        (size_q),
    .is_unsigned (op_q == MemLoadu),
    .value       (load_val)
  );

  // Next-state, bus and writeback decisions; wbWe/fault default low so they pulse.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    size_d    = size_q;
    lane_d    = lane_q;
    rd_d      = rd_q;
    rwe_d     = rwe_q;
    rdata_d   = rdata_q;
    aborted_d = aborted_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    wb_data_d = wb_data_q;
    wb_rd_d   = wb_rd_q;
    wb_we_d   = 1'b0;
    fault_d   = 1'b0;
    stall     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (op_in == MemNone) begin
          wb_data_d = aluIn;
          wb_rd_d   = rdIn;
          wb_we_d   = regWriteIn;
        end else if (bad_in) begin
          fault_d = 1'b1;
        end else begin
          stall     = 1'b1;
          op_d      = op_in;
          size_d    = size_in;
          lane_d    = addrIn[1:0];
          rd_d      = rdIn;
          rwe_d     = regWriteIn;
          aborted_d = 1'b0;
          cnt_d     = '0;
          req_d     = 1'b1;
          we_d      = (op_in == MemStore);
          addr_d    = {addrIn[31:2], 2'b00};
          be_d      = st_be;
          wdata_d   = st_wdata;
          state_d   = StReq;
        end
      end
      StReq: begin
        stall = 1'b1;
        if (dmem_ready) begin
          // Ready wins even on the cycle the timeout would fire.
          rdata_d = dmem_rdata;
          req_d   = 1'b0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_inc[15:0];
          if (cnt_inc >= 17'(TIMEOUT)) begin
            req_d     = 1'b0;
            aborted_d = 1'b1;
            state_d   = StDone;
          end
        end
      end
      StDone: begin
        // Upstream advances on this edge; whatever sits on the inputs is stale.
        state_d = StIdle;
        if (aborted_q) begin
          fault_d = 1'b1;
        end else if (op_q != MemStore) begin
          wb_data_d = load_val;
          wb_rd_d   = rd_q;
          wb_we_d   = rwe_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      op_q      <= MemNone;
      size_q    <= SizeByte;
      lane_q    <= '0;
      rd_q      <= '0;
      rwe_q     <= 1'b0;
      rdata_q   <= '0;
      aborted_q <= 1'b0;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      wb_data_q <= '0;
      wb_rd_q   <= '0;
      wb_we_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      size_q    <= size_d;
      lane_q    <= lane_d;
      rd_q      <= rd_d;
      rwe_q     <= rwe_d;
      rdata_q   <= rdata_d;
      aborted_q <= aborted_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      wb_data_q <= wb_data_d;
      wb_rd_q   <= wb_rd_d;
      wb_we_q   <= wb_we_d;
      fault_q   <= fault_d;
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;
  assign wbData     = wb_data_q;
  assign wbRd       = wb_rd_q;
  assign wbWe       = wb_we_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized ops
// against an arithmetic reference model and a word-array memory.
module tb_mem_stage;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  memOpIn, memSizeIn;
  logic [31:0] addrIn, dinIn, aluIn;
  logic [4:0]  rdIn;
  logic        regWriteIn;
  logic        stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, wbData;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [4:0]  wbRd;
  logic        wbWe, fault;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] tb_mem [256];

  typedef struct {
    int          stall_cycles;
    int          req_cycles;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    bit          stable;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_we;
    logic        fault;
    logic        req_after;
    logic        wb_we_after;
    logic        fault_after;
  } obs_t;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .memOpIn    (memOpIn),
    .memSizeIn  (memSizeIn),
    .addrIn     (addrIn),
    .dinIn      (dinIn),
    .aluIn      (aluIn),
    .rdIn       (rdIn),
    .regWriteIn (regWriteIn),
    .stall      (stall),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_be    (dmem_be),
    .dmem_wdata (dmem_wdata),
    .dmem_ready (dmem_ready),
    .dmem_rdata (dmem_rdata),
    .wbData     (wbData),
    .wbRd       (wbRd),
    .wbWe       (wbWe),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  // ---- reference model ----
  function automatic int nbytes(int size);
    return (size == 0) ? 1 : (size == 1) ? 2 : 4;
  endfunction

  function automatic bit is_fault(int size, logic [31:0] addr);
    return (size == 3) || ((addr % nbytes(size)) != 0);
  endfunction

  function automatic logic [3:0] exp_be(int size, logic [31:0] addr);
    int t;
    t = ((1 << nbytes(size)) - 1) << (addr % 4);
    return t[3:0];
  endfunction

  function automatic logic [31:0] exp_wdata(int size, logic [31:0] din);
    if (nbytes(size) == 1) return (din % 256) * 32'h0101_0101;
    if (nbytes(size) == 2) return (din % 65536) * 32'h0001_0001;
    return din;
  endfunction

  function automatic logic [31:0] exp_load(logic [31:0] word, logic [31:0] addr, int size,
                                           bit uns);
    longint v, span;
    int nb;
    nb = nbytes(size);
    if (nb == 4) return word;
    v    = longint'(word) >> (8 * (addr % 4));
    span = longint'(1) << (8 * nb);
    v    = v % span;
    if (!uns && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  // Present one instruction, act as the memory, collect what the DUT did.
  // Entered and left at a falling edge.
  task automatic drive_op(input logic [1:0] op, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] din,
                          input logic [31:0] alu, input logic [4:0] rd, input logic rwe,
                          input int waits, output obs_t o);
    int guard;
    o = '{default: 0};
    o.stable = 1'b1;
    memOpIn = op; memSizeIn = size; addrIn = addr; dinIn = din;
    aluIn = alu; rdIn = rd; regWriteIn = rwe; dmem_ready = 1'b0;
    #1 if (stall) o.stall_cycles++;
    @(posedge clk); @(negedge clk);
    if (dmem_req) begin
      o.addr = dmem_addr; o.be = dmem_be; o.wdata = dmem_wdata; o.we = dmem_we;
      guard = 0;
      while (dmem_req && guard < 100) begin
        if (dmem_addr !== o.addr || dmem_be !== o.be || dmem_wdata !== o.wdata ||
            dmem_we !== o.we) o.stable = 1'b0;
        dmem_ready = (o.req_cycles == waits);
        dmem_rdata = tb_mem[dmem_addr[9:2]];
        #1 if (stall) o.stall_cycles++;
        o.req_cycles++;
        guard++;
        @(posedge clk); @(negedge clk);
        dmem_ready = 1'b0;
        dmem_rdata = $urandom;
      end
      if (dmem_req) o.req_cycles = -1;
      #1 if (stall) o.stall_cycles++;
      @(posedge clk); @(negedge clk);
    end
    o.wb_data = wbData; o.wb_rd = wbRd; o.wb_we = wbWe; o.fault = fault;
    o.req_after = dmem_req;
    memOpIn = 2'd0; regWriteIn = 1'b0; aluIn = $urandom; rdIn = 5'($urandom);
    @(posedge clk); @(negedge clk);
    o.wb_we_after = wbWe; o.fault_after = fault;
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    reset = 1'b1; memOpIn = 2'd0; memSizeIn = 2'd0; addrIn = '0; dinIn = '0;
    aluIn = 32'h5555_5555; rdIn = 5'd3; regWriteIn = 1'b1; dmem_ready = 1'b0; dmem_rdata = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata} !== '0) begin
      n_fail++; $display("FAIL reset_bus got req=%b be=%h addr=%h wdata=%h want all 0",
                         dmem_req, dmem_be, dmem_addr, dmem_wdata);
    end
    n_checks++;
    if ({wbData, wbRd, wbWe, fault, stall} !== '0) begin
      n_fail++; $display("FAIL reset_wb got wbData=%h wbRd=%0d wbWe=%b fault=%b stall=%b want 0",
                         wbData, wbRd, wbWe, fault, stall);
    end
    reset = 1'b0; regWriteIn = 1'b0;
  endtask

  task automatic test_alu();
    obs_t o;
    drive_op(2'd0, 2'd0, 32'h0, 32'h0, 32'h1234, 5'd5, 1'b1, 0, o);
    n_checks++;
    if (o.wb_data !== 32'h1234 || o.wb_rd !== 5'd5 || o.wb_we !== 1'b1) begin
      n_fail++; $display("FAIL alu_wb got %h/%0d/%b want 00001234/5/1", o.wb_data, o.wb_rd, o.wb_we);
    end
    n_checks++;
    if (o.stall_cycles != 0 || o.req_cycles != 0 || o.wb_we_after !== 1'b0) begin
      n_fail++; $display("FAIL alu_side got stall=%0d req=%0d we_after=%b want 0/0/0",
                         o.stall_cycles, o.req_cycles, o.wb_we_after);
    end
  endtask

  task automatic test_store_byte();
    obs_t o;
    drive_op(2'd2, 2'd0, 32'h103, 32'hAABB_CCDD, 32'h0, 5'd1, 1'b1, 0, o);
    n_checks++;
    if (o.addr !== 32'h100 || o.be !== 4'b1000 || o.wdata !== 32'hDDDD_DDDD || o.we !== 1'b1) begin
      n_fail++; $display("FAIL store_bus got addr=%h be=%b wdata=%h we=%b want 100/1000/dddddddd/1",
                         o.addr, o.be, o.wdata, o.we);
    end
    n_checks++;
    if (o.stall_cycles != 2 || o.wb_we !== 1'b0 || o.fault !== 1'b0) begin
      n_fail++; $display("FAIL store_done got stall=%0d wbWe=%b fault=%b want 2/0/0",
                         o.stall_cycles, o.wb_we, o.fault);
    end
  endtask

  task automatic test_load_half();
    obs_t o;
    tb_mem[8'h80] = 32'h8001_FFFF;
    drive_op(2'd1, 2'd1, 32'h202, 32'h0, 32'h0, 5'd12, 1'b1, 3, o);
    n_checks++;
    if (o.stall_cycles != 5 || o.wb_data !== 32'hFFFF_8001 || o.wb_we !== 1'b1 || o.wb_rd !== 5'd12)
    begin
      n_fail++; $display("FAIL load_half got stall=%0d data=%h we=%b rd=%0d want 5/ffff8001/1/12",
                         o.stall_cycles, o.wb_data, o.wb_we, o.wb_rd);
    end
    drive_op(2'd3, 2'd1, 32'h202, 32'h0, 32'h0, 5'd13, 1'b1, 3, o);
    n_checks++;
    if (o.stall_cycles != 5 || o.wb_data !== 32'h0000_8001 || o.wb_we !== 1'b1) begin
      n_fail++; $display("FAIL loadu_half got stall=%0d data=%h we=%b want 5/00008001/1",
                         o.stall_cycles, o.wb_data, o.wb_we);
    end
  endtask

  task automatic test_fault();
    obs_t o;
    drive_op(2'd1, 2'd2, 32'h301, 32'h0, 32'h0, 5'd4, 1'b1, 0, o);
    n_checks++;
    if (o.fault !== 1'b1 || o.fault_after !== 1'b0) begin
      n_fail++; $display("FAIL misalign_fault got pulse=%b after=%b want 1/0", o.fault, o.fault_after);
    end
    n_checks++;
    if (o.req_cycles != 0 || o.wb_we !== 1'b0 || o.stall_cycles != 0) begin
      n_fail++; $display("FAIL misalign_side got req=%0d wbWe=%b stall=%0d want 0/0/0",
                         o.req_cycles, o.wb_we, o.stall_cycles);
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    drive_op(2'd1, 2'd2, 32'h40, 32'h0, 32'h0, 5'd6, 1'b1, 1000, o);
    n_checks++;
    if (o.req_cycles != TO || o.stall_cycles != TO + 1) begin
      n_fail++; $display("FAIL timeout_len got req=%0d stall=%0d want %0d/%0d",
                         o.req_cycles, o.stall_cycles, TO, TO + 1);
    end
    n_checks++;
    if (o.fault !== 1'b1 || o.wb_we !== 1'b0 || o.req_after !== 1'b0 || o.fault_after !== 1'b0) begin
      n_fail++; $display("FAIL timeout_done got fault=%b wbWe=%b req=%b after=%b want 1/0/0/0",
                         o.fault, o.wb_we, o.req_after, o.fault_after);
    end
  endtask

  task automatic test_reset_mid_req();
    obs_t o;
    memOpIn = 2'd1; memSizeIn = 2'd2; addrIn = 32'h44; regWriteIn = 1'b1; rdIn = 5'd7;
    dmem_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (dmem_req !== 1'b1) begin
      n_fail++; $display("FAIL midreq_pre got req=%b want 1", dmem_req);
    end
    reset = 1'b1; memOpIn = 2'd0; regWriteIn = 1'b0;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if ({dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, stall} !== '0) begin
      n_fail++; $display("FAIL midreq_bus got req=%b be=%h addr=%h stall=%b want 0",
                         dmem_req, dmem_be, dmem_addr, stall);
    end
    n_checks++;
    if ({wbData, wbRd, wbWe, fault} !== '0) begin
      n_fail++; $display("FAIL midreq_wb got %h/%0d/%b/%b want 0", wbData, wbRd, wbWe, fault);
    end
    reset = 1'b0;
    drive_op(2'd0, 2'd0, 32'h0, 32'h0, 32'hCAFE, 5'd9, 1'b1, 0, o);
    n_checks++;
    if (o.wb_data !== 32'hCAFE || o.wb_rd !== 5'd9 || o.wb_we !== 1'b1) begin
      n_fail++; $display("FAIL postreset_alu got %h/%0d/%b want 0000cafe/9/1",
                         o.wb_data, o.wb_rd, o.wb_we);
    end
  endtask

  task automatic test_random();
    obs_t o;
    for (int i = 0; i < 60; i++) begin
      int op, size, waits, exp_stall, exp_req;
      logic [31:0] addr, din, alu, word;
      logic [4:0] rd;
      logic rwe, exp_we;
      bit mem, flt, acc, ab, is_ld;
      op = $urandom_range(0, 3); size = $urandom_range(0, 3);
      addr = $urandom_range(0, 1023); din = $urandom; alu = $urandom;
      rd = 5'($urandom); rwe = 1'($urandom);
      waits = ($urandom_range(0, 7) == 0) ? 50 : $urandom_range(0, 3);
      word  = tb_mem[addr[9:2]];
      mem   = (op != 0);
      flt   = mem && is_fault(size, addr);
      acc   = mem && !flt;
      ab    = acc && (waits >= TO);
      is_ld = (op == 1) || (op == 3);
      exp_req   = !acc ? 0 : ab ? TO : waits + 1;
      exp_stall = !acc ? 0 : exp_req + 1;
      exp_we    = (!mem || (acc && !ab && is_ld)) ? rwe : 1'b0;
      drive_op(2'(op), 2'(size), addr, din, alu, rd, rwe, waits, o);
      n_checks++;
      if (o.stall_cycles != exp_stall || o.req_cycles != exp_req) begin
        n_fail++; $display("FAIL rnd%0d timing got stall=%0d req=%0d want %0d/%0d",
                           i, o.stall_cycles, o.req_cycles, exp_stall, exp_req);
      end
      n_checks++;
      if (o.wb_we !== exp_we || o.fault !== (flt || ab)) begin
        n_fail++; $display("FAIL rnd%0d flags got wbWe=%b fault=%b want %b/%b",
                           i, o.wb_we, o.fault, exp_we, flt || ab);
      end
      n_checks++;
      if (o.req_after !== 1'b0 || o.wb_we_after !== 1'b0 || o.fault_after !== 1'b0) begin
        n_fail++; $display("FAIL rnd%0d pulses got req=%b we=%b fault=%b want 0/0/0",
                           i, o.req_after, o.wb_we_after, o.fault_after);
      end
      if (acc) begin
        n_checks++;
        if (o.addr !== {addr[31:2], 2'b00} || o.be !== exp_be(size, addr) ||
            o.we !== (op == 2) || !o.stable) begin
          n_fail++; $display("FAIL rnd%0d bus got addr=%h be=%b we=%b stable=%0d want %h/%b/%b/1",
                             i, o.addr, o.be, o.we, o.stable, {addr[31:2], 2'b00},
                             exp_be(size, addr), op == 2);
        end
      end
      if (acc && op == 2) begin
        n_checks++;
        if (o.wdata !== exp_wdata(size, din)) begin
          n_fail++; $display("FAIL rnd%0d wdata got %h want %h", i, o.wdata, exp_wdata(size, din));
        end
        if (!ab) begin
          for (int b = 0; b < 4; b++)
            if (o.be[b]) tb_mem[addr[9:2]][8*b +: 8] = o.wdata[8*b +: 8];
        end
      end
      if (!mem || (acc && !ab && is_ld)) begin
        n_checks++;
        if (o.wb_data !== (mem ? exp_load(word, addr, size, op == 3) : alu) || o.wb_rd !== rd) begin
          n_fail++; $display("FAIL rnd%0d wbdata got %h/%0d want %h/%0d", i, o.wb_data, o.wb_rd,
                             mem ? exp_load(word, addr, size, op == 3) : alu, rd);
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 256; k++) tb_mem[k] = $urandom;
    test_reset();
    test_alu();
    test_store_byte();
    test_load_half();
    test_fault();
    test_timeout();
    test_reset_mid_req();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
